// File: rtl/keccak_permute.sv
// Iterative Keccak-p[b,nr] permutation engine with valid/ready handshakes on both sides.
// Build option: define KECCAK_UNROLL2_EN to apply two rounds per clock (nr must then be even).

module keccak_round #(
  parameter int l = 6,
  parameter int w = 2**l,
  parameter int b = 25*w
) (
  input  logic [b-1:0] state_i,
  input  logic [l:0]   rc_i,
  output logic [b-1:0] state_o
);
  function automatic logic [w-1:0] rotl(input logic [w-1:0] v, input int unsigned r);
    int unsigned s;
    s = r % w;
    return (v << s) | (v >> ((w - s) % w));
  endfunction

  // Rho offset of lane (x,y), walked along the (x,y) -> (y,2x+3y) orbit from (1,0).
  function automatic int unsigned rho_off(input int unsigned x, input int unsigned y);
    int unsigned cx, cy, nx;
    cx = 1;
    cy = 0;
    for (int unsigned t = 0; t < 24; t++) begin
      if (cx == x && cy == y) return ((t + 1) * (t + 2) / 2) % w;
      nx = cy;
      cy = (2 * cx + 3 * cy) % 5;
      cx = nx;
    end
    return 0;
  endfunction

  logic [5*w-1:0] c;
  logic [5*w-1:0] d;
  logic [b-1:0]   bp;
  logic [w-1:0]   rc_lane;

  always_comb begin
    c       = '0;
    d       = '0;
    bp      = '0;
    rc_lane = '0;
    state_o = '0;
    for (int unsigned x = 0; x < 5; x++)
      for (int unsigned y = 0; y < 5; y++)
        c[w*x +: w] = c[w*x +: w] ^ state_i[w*(x+5*y) +: w];
    for (int unsigned x = 0; x < 5; x++)
      d[w*x +: w] = c[w*((x+4)%5) +: w] ^ rotl(c[w*((x+1)%5) +: w], 1);
    // theta + rho, scattered straight into pi positions
    for (int unsigned x = 0; x < 5; x++)
      for (int unsigned y = 0; y < 5; y++)
        bp[w*(y + 5*((2*x+3*y)%5)) +: w] = rotl(state_i[w*(x+5*y) +: w] ^ d[w*x +: w], rho_off(x, y));
    for (int unsigned x = 0; x < 5; x++)
      for (int unsigned y = 0; y < 5; y++)
        state_o[w*(x+5*y) +: w] = bp[w*(x+5*y) +: w] ^
                                  (~bp[w*((x+1)%5 + 5*y) +: w] & bp[w*((x+2)%5 + 5*y) +: w]);
    for (int unsigned j = 0; j <= l; j++)
      rc_lane = rc_lane | ((w'(rc_i >> j) & w'(1)) << (2**j - 1));
    state_o[w-1:0] = state_o[w-1:0] ^ rc_lane;
  end
endmodule

module keccak_permute #(
  parameter int l  = 6,
  parameter int w  = 2**l,
  parameter int b  = 25*w,
  parameter int nr = 12+2*l
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [b-1:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [b-1:0] out_state,
  output logic         busy
);
  localparam int unsigned CW    = $clog2(nr+1);
  localparam int unsigned NRMAX = 12+2*l;
`ifdef KECCAK_UNROLL2_EN
  localparam int unsigned RPE = 2;
`else
  localparam int unsigned RPE = 1;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  function automatic logic [7:0] lfsr_adv(input logic [7:0] r, input int unsigned n);
    logic [7:0] s;
    s = r;
    for (int unsigned i = 0; i < n; i++)
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
    return s;
  endfunction

  localparam logic [7:0] SEED = lfsr_adv(8'h01, 7*(NRMAX-nr));

  if (nr < 1 || nr > NRMAX) begin : g_nr_range
    $error("keccak_permute: nr out of range");
  end
`ifdef KECCAK_UNROLL2_EN
  if (nr % 2 != 0) begin : g_nr_odd
    $error("keccak_permute: nr must be even when two rounds run per clock");
  end
`endif

  fsm_e         fsm_q, fsm_d;
  logic [b-1:0] state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic [7:0]   lfsr_q, lfsr_d;
  logic [l:0]   rc0;
  logic [b-1:0] r1_state, r2_state;

  always_comb begin
    logic [7:0] s;
    rc0 = '0;
    s   = lfsr_q;
    for (int unsigned j = 0; j <= l; j++) begin
      rc0 = rc0 | ((l+1)'(s[0]) << j);
      s   = lfsr_adv(s, 1);
    end
  end

  keccak_round #(.l(l), .w(w), .b(b)) u_round0 (
    .state_i(state_q),
    .rc_i   (rc0),
    .state_o(r1_state)
  );

`ifdef KECCAK_UNROLL2_EN
  logic [l:0] rc1;

  always_comb begin
    logic [7:0] s;
    rc1 = '0;
    s   = lfsr_adv(lfsr_q, 7);
    for (int unsigned j = 0; j <= l; j++) begin
      rc1 = rc1 | ((l+1)'(s[0]) << j);
      s   = lfsr_adv(s, 1);
    end
  end

  keccak_round #(.l(l), .w(w), .b(b)) u_round1 (
    .state_i(r1_state),
    .rc_i   (rc1),
    .state_o(r2_state)
  );
`else
  assign r2_state = r1_state;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    ctr_d   = ctr_q;
    lfsr_d  = lfsr_q;
    unique case (fsm_q)
      IDLE: if (in_valid) begin
        fsm_d   = RUN;
        state_d = in_state;
        ctr_d   = '0;
        lfsr_d  = SEED;
      end
      RUN: begin
        state_d = r2_state;
        ctr_d   = ctr_q + CW'(RPE);
        lfsr_d  = lfsr_adv(lfsr_q, 7*RPE);
        if (ctr_q == CW'(nr - RPE)) fsm_d = DONE;
      end
      DONE: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      ctr_q   <= '0;
      lfsr_q  <= SEED;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ctr_q   <= ctr_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == RUN);
  assign out_state = state_q;
endmodule
